fp_div_iter: RTL and testbench



---
 rtl/fp_div_iter_pkg.sv | 26 ++
 rtl/fp_div_round.sv | 63 ++++++
 rtl/fp_div_iter.sv | 169 ++++++++++++++++
 tb/tb_fp_div_iter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fp_div_iter_pkg.sv
// Shared types and constants for the iterative single-precision divider.
package fp_div_iter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DIVIDE,
    ROUND,
    DONE,
    SPECIAL_DONE
  } fp_div_state_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  localparam logic [31:0] FP_CANON_NAN = 32'h7FC00000;
  localparam logic [31:0] FP_POS_INF   = 32'h7F800000;
  localparam int unsigned FP_EXP_BIAS  = 127;
  localparam int unsigned FP_DIV_QBITS = 27;
  localparam int unsigned FP_MANT_W    = 24;
  localparam int unsigned FP_EXP_W     = 10;
  localparam int unsigned FP_REM_W     = 26;

endpackage

// File: rtl/fp_div_round.sv
// Normalizes the raw quotient, rounds to nearest-even and clamps to the
// single-precision range (overflow to inf, underflow flushed to zero).
module fp_div_round
  import fp_div_iter_pkg::*;
(
  input  logic [FP_DIV_QBITS-1:0]    q_i,
  input  logic                       rem_nz_i,
  input  logic signed [FP_EXP_W-1:0] exp_i,
  input  logic                       sign_i,
  output logic [31:0]                result_c_o
);

  logic [FP_MANT_W-1:0]       mant;
  logic                       guard;
  logic                       sticky;
  logic                       round_up;
  logic [FP_MANT_W:0]         mant_r;
  logic [FP_MANT_W-2:0]       frac_f;
  logic signed [FP_EXP_W-1:0] exp_n;
  logic signed [FP_EXP_W-1:0] exp_f;

  always_comb begin
    mant       = '0;
    guard      = 1'b0;
    sticky     = 1'b0;
    exp_n      = exp_i;
    frac_f     = '0;
    exp_f      = exp_i;
    result_c_o = '0;

    // Quotient lies in [2^25, 2^27); the top bit decides the binade.
    if (q_i[26]) begin
      mant   = q_i[26:3];
      guard  = q_i[2];
      sticky = (|q_i[1:0]) | rem_nz_i;
    end else begin
      mant   = q_i[25:2];
      guard  = q_i[1];
      sticky = q_i[0] | rem_nz_i;
      exp_n  = exp_i - 10'sd1;
    end

    round_up = guard & (sticky | mant[0]);
    mant_r   = {1'b0, mant} + 25'(round_up);

    if (mant_r[24]) begin
      frac_f = mant_r[23:1];
      exp_f  = exp_n + 10'sd1;
    end else begin
      frac_f = mant_r[22:0];
      exp_f  = exp_n;
    end

    if (exp_f >= 10'sd255) begin
      result_c_o = FP_POS_INF | {sign_i, 31'd0};
    end else if (exp_f <= 10'sd0) begin
      result_c_o = {sign_i, 31'd0};
    end else begin
      result_c_o = {sign_i, exp_f[7:0], frac_f};
    end
  end

endmodule

// File: rtl/fp_div_iter.sv
// Iterative IEEE-754 single-precision divider: restoring division resolving
// ITER_PER_CYCLE quotient bits per clock, then round-to-nearest-even.
module fp_div_iter
  import fp_div_iter_pkg::*;
#(
  parameter int unsigned ITER_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [31:0] result,
  output logic        div_by_zero
);

  localparam int unsigned N_CYC = FP_DIV_QBITS / ITER_PER_CYCLE;
  localparam int unsigned CNT_W = 5;

  fp_div_state_t              state_q, state_d;
  logic [FP_REM_W-1:0]        rem_q, rem_d;
  logic [FP_DIV_QBITS-1:0]    quo_q, quo_d;
  logic [FP_MANT_W-1:0]       m2_q, m2_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic signed [FP_EXP_W-1:0] exp_q, exp_d;
  logic                       sign_q, sign_d;
  logic [31:0]                result_q, result_d;
  logic                       dbz_q, dbz_d;

  fp32_t       a, b;
  logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic        special;
  logic [31:0] spec_res;
  logic        spec_dbz;
  logic [31:0] rounded_c;

  // Special-operand classification; exponent 0 counts as zero.
  always_comb begin
    a        = fp32_t'(op1);
    b        = fp32_t'(op2);
    nan_a    = (&a.exp) & (|a.frac);
    nan_b    = (&b.exp) & (|b.frac);
    inf_a    = (&a.exp) & ~(|a.frac);
    inf_b    = (&b.exp) & ~(|b.frac);
    zero_a   = ~(|a.exp);
    zero_b   = ~(|b.exp);
    special  = nan_a | nan_b | inf_a | inf_b | zero_a | zero_b;
    spec_dbz = 1'b0;
    if (nan_a | nan_b | (zero_a & zero_b) | (inf_a & inf_b)) begin
      spec_res = FP_CANON_NAN;
    end else if (inf_a) begin
      spec_res = FP_POS_INF | {a.sign ^ b.sign, 31'd0};
    end else if (inf_b) begin
      spec_res = {a.sign ^ b.sign, 31'd0};
    end else if (zero_b) begin
      spec_res = FP_POS_INF | {a.sign ^ b.sign, 31'd0};
      spec_dbz = 1'b1;
    end else begin
      spec_res = {a.sign ^ b.sign, 31'd0};
    end
  end

  fp_div_round u_round (
    .q_i        (quo_q),
    .rem_nz_i   (|rem_q),
    .exp_i      (exp_q),
    .sign_i     (sign_q),
    .result_c_o (rounded_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      quo_q    <= '0;
      m2_q     <= '0;
      cnt_q    <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      m2_q     <= m2_d;
      cnt_q    <= cnt_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  logic [FP_REM_W-1:0]     rem_t;
  logic [FP_DIV_QBITS-1:0] quo_t;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    m2_d     = m2_q;
    cnt_d    = cnt_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    rem_t    = rem_q;
    quo_t    = quo_q;

    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          if (special) begin
            result_d = spec_res;
            dbz_d    = spec_dbz;
            state_d  = SPECIAL_DONE;
          end else begin
            rem_d   = FP_REM_W'({1'b1, a.frac});
            m2_d    = {1'b1, b.frac};
            quo_d   = '0;
            cnt_d   = '0;
            exp_d   = 10'(a.exp) - 10'(b.exp) + 10'(FP_EXP_BIAS);
            sign_d  = a.sign ^ b.sign;
            state_d = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        // Remainder stays below 2*m2, so one compare/subtract per bit.
        for (int i = 0; i < int'(ITER_PER_CYCLE); i++) begin
          if (rem_t >= FP_REM_W'(m2_q)) begin
            rem_t = rem_t - FP_REM_W'(m2_q);
            quo_t = {quo_t[FP_DIV_QBITS-2:0], 1'b1};
          end else begin
            quo_t = {quo_t[FP_DIV_QBITS-2:0], 1'b0};
          end
          rem_t = {rem_t[FP_REM_W-2:0], 1'b0};
        end
        rem_d = rem_t;
        quo_d = quo_t;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == CNT_W'(N_CYC - 1)) begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        result_d = rounded_c;
        dbz_d    = 1'b0;
        state_d  = DONE;
      end
      DONE, SPECIAL_DONE: begin
        if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign start_ready  = (state_q == IDLE);
  assign result_valid = (state_q == DONE) || (state_q == SPECIAL_DONE);
  assign result       = result_q;
  assign div_by_zero  = dbz_q;

endmodule

// File: tb/tb_fp_div_iter.sv
// Bench for fp_div_iter: ITER_PER_CYCLE=1 and =3 instances side by side,
// directed corner cases plus random operands against an integer reference.
module tb_fp_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid;
  logic        result_ready;
  logic [31:0] op1, op2;
  logic        sr1, rv1, dz1, sr3, rv3, dz3;
  logic [31:0] res1, res3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fp_div_iter #(.ITER_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(sr1),
    .op1(op1), .op2(op2), .result_valid(rv1), .result_ready(result_ready),
    .result(res1), .div_by_zero(dz1)
  );

  fp_div_iter #(.ITER_PER_CYCLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(sr3),
    .op1(op1), .op2(op2), .result_valid(rv3), .result_ready(result_ready),
    .result(res3), .div_by_zero(dz3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (op1=%h op2=%h)", tag, got, exp, op1, op2);
    end
  endtask

  // Integer reference: exact quotient/remainder, then the stated rounding rules.
  function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] res, output logic dz,
                                  output logic spec);
    longint unsigned m1, m2, q, r, mant;
    int   e;
    logic s, g, st;
    logic nan1, nan2, inf1, inf2, z1, z2;
    nan1 = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    nan2 = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    inf1 = (x[30:23] == 8'hFF) && (x[22:0] == 0);
    inf2 = (y[30:23] == 8'hFF) && (y[22:0] == 0);
    z1   = (x[30:23] == 8'h00);
    z2   = (y[30:23] == 8'h00);
    s    = x[31] ^ y[31];
    res  = 32'd0;
    dz   = 1'b0;
    spec = 1'b1;
    if (nan1 || nan2 || (z1 && z2) || (inf1 && inf2)) res = 32'h7FC00000;
    else if (inf1) res = {s, 31'h7F800000};
    else if (inf2) res = {s, 31'd0};
    else if (z2) begin res = {s, 31'h7F800000}; dz = 1'b1; end
    else if (z1) res = {s, 31'd0};
    else begin
      spec = 1'b0;
      m1 = {40'd0, 1'b1, x[22:0]};
      m2 = {40'd0, 1'b1, y[22:0]};
      q  = (m1 << 26) / m2;
      r  = (m1 << 26) % m2;
      e  = int'(x[30:23]) - int'(y[30:23]) + 127;
      if (q >= 64'd67108864) begin
        mant = q >> 3;
        g    = q[2];
        st   = (q[1:0] != 0) || (r != 0);
      end else begin
        mant = (q >> 2) & 64'hFFFFFF;
        g    = q[1];
        st   = q[0] || (r != 0);
        e    = e - 1;
      end
      if (g && (st || mant[0])) mant = mant + 1;
      if (mant == 64'd16777216) begin mant = mant >> 1; e = e + 1; end
      if (e >= 255) res = {s, 31'h7F800000};
      else if (e <= 0) res = {s, 31'd0};
      else res = {s, 8'(e), mant[22:0]};
    end
  endfunction

  // One transaction through both instances; hold>0 stalls the consumer.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] r_exp, input logic dz_exp,
                        input logic spec, input int hold);
    int lat, lat1, lat3;
    check("idle_ready", 32'({sr1, sr3}), 32'd3);
    op1 = x; op2 = y; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    lat = 1; lat1 = 0; lat3 = 0;
    while (lat < 60) begin
      if (rv1 && lat1 == 0) lat1 = lat;
      if (rv3 && lat3 == 0) lat3 = lat;
      if (rv1 && rv3) break;
      @(posedge clk); #1;
      lat++;
    end
    check("latency_ipc1", 32'(lat1), spec ? 32'd1 : 32'd29);
    check("latency_ipc3", 32'(lat3), spec ? 32'd1 : 32'd11);
    check("result_ipc1", res1, r_exp);
    check("result_ipc3", res3, r_exp);
    check("dbz_ipc1", 32'(dz1), 32'(dz_exp));
    check("dbz_ipc3", 32'(dz3), 32'(dz_exp));
    for (int k = 0; k < hold; k++) begin
      start_valid = 1'b1;
      op1 = $urandom; op2 = $urandom;
      @(posedge clk); #1;
      check("hold_result", res1, r_exp);
      check("hold_dbz", 32'(dz1), 32'(dz_exp));
      check("hold_flags", 32'({rv1, sr1, rv3, sr3}), 32'b1010);
    end
    start_valid  = 1'b0;
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    check("handoff_flags", 32'({rv1, sr1, rv3, sr3}), 32'b0101);
  endtask

  function automatic logic [31:0] rnd_op();
    logic [7:0] e;
    logic [22:0] f;
    int kind;
    kind = int'($urandom_range(0, 9));
    f = 23'($urandom);
    if (kind == 0) begin
      e = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
      if ($urandom_range(0, 1) == 0) f = '0;
    end else if (kind <= 2) begin
      e = 8'($urandom_range(1, 254));
    end else begin
      e = 8'($urandom_range(107, 147));
    end
    return {1'($urandom), e, f};
  endfunction

  logic [31:0] da [9] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'hBF800000,
                          32'h00000000, 32'h7FC00001, 32'h7F000000, 32'h00800000,
                          32'hC0C00000};
  logic [31:0] db [9] = '{32'h40000000, 32'h40400000, 32'h3F800000, 32'h00000000,
                          32'h00000000, 32'h3F800000, 32'h3E800000, 32'h40000000,
                          32'h40000000};
  logic [31:0] dr [9] = '{32'h40400000, 32'h3EAAAAAB, 32'h3F800000, 32'hFF800000,
                          32'h7FC00000, 32'h7FC00000, 32'h7F800000, 32'h00000000,
                          32'hC0400000};
  logic        dd [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic        ds [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    logic [31:0] x, y, r;
    logic dz, sp;
    rst = 1'b1; start_valid = 1'b0; result_ready = 1'b0; op1 = '0; op2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_flags", 32'({rv1, sr1, rv3, sr3}), 32'b0101);
    check("reset_result", res1, 32'd0);
    check("reset_dbz", 32'({dz1, dz3}), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_op(da[i], db[i], dr[i], dd[i], ds[i], (i == 0) ? 5 : 0);
    end

    // Reset while both instances are still iterating.
    op1 = 32'h40490FDB; op2 = 32'h3FB504F3; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midop_reset_flags", 32'({rv1, sr1, rv3, sr3}), 32'b0101);
    repeat (35) @(posedge clk);
    #1;
    check("midop_no_result", 32'({rv1, sr1, rv3, sr3}), 32'b0101);
    run_op(32'h3FC00000, 32'h3F000000, 32'h40400000, 1'b0, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      x = rnd_op();
      y = rnd_op();
      ref_div(x, y, r, dz, sp);
      run_op(x, y, r, dz, sp, int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
